// File: rtl/multiplier_pkg.sv
// riscv_defs: shared XLEN constant, multiply op encoding and select-priority decode.
package riscv_defs;
    localparam int XLEN = 32;
    typedef enum logic [1:0] {
        OP_MUL    = 2'd0,
        OP_MULH   = 2'd1,
        OP_MULHSU = 2'd2,
        OP_MULHU  = 2'd3
    } mul_op_e;
    // MUL wins over MULH over MULHSU; MULHU is the fall-through.
    function automatic mul_op_e decode_op(input logic m, input logic mh, input logic msu);
        return m ? OP_MUL : mh ? OP_MULH : msu ? OP_MULHSU : OP_MULHU;
    endfunction
endpackage

// File: rtl/multiplier_if.sv
// multiplier_if: operand/select request and product response bundle for the multiply unit.
interface multiplier_if;
    import riscv_defs::*;
    logic            valid_i;
    logic [XLEN-1:0] op1_i;
    logic [XLEN-1:0] op2_i;
    logic            is_mul_i;
    logic            is_mulh_i;
    logic            is_mulhsu_i;
    logic            is_mulhu_i;
    logic [XLEN-1:0] product_o;
    logic            valid_o;
    modport master (
        output valid_i, op1_i, op2_i, is_mul_i, is_mulh_i, is_mulhsu_i, is_mulhu_i,
        input  product_o, valid_o
    );
    modport slave (
        input  valid_i, op1_i, op2_i, is_mul_i, is_mulh_i, is_mulhsu_i, is_mulhu_i,
        output product_o, valid_o
    );
endinterface

// File: rtl/multiplier_mul_core.sv
// mul_core: combinational 33x33 signed multiply built from four 17-bit partial products.
module mul_core (
    input  logic [32:0] a,
    input  logic [32:0] b,
    output logic [65:0] p
);
    logic [33:0] a_hi, a_lo, b_hi, b_lo;
    logic [33:0] pp_hh, pp_hl, pp_lh, pp_ll;
    // Upper slices carry the sign; lower slices are plain 16-bit magnitudes.
    assign a_hi  = {{17{a[32]}}, a[32:16]};
    assign b_hi  = {{17{b[32]}}, b[32:16]};
    assign a_lo  = {18'b0, a[15:0]};
    assign b_lo  = {18'b0, b[15:0]};
    assign pp_hh = a_hi * b_hi;
    assign pp_hl = a_hi * b_lo;
    assign pp_lh = a_lo * b_hi;
    assign pp_ll = a_lo * b_lo;
    assign p = {pp_hh, 32'b0}
             + {{16{pp_hl[33]}}, pp_hl, 16'b0}
             + {{16{pp_lh[33]}}, pp_lh, 16'b0}
             + {32'b0, pp_ll};
endmodule

// File: rtl/multiplier.sv
// multiplier: RV32M MUL/MULH/MULHSU/MULHU unit, latency 1 (2 with MULTIPLIER_PIPE2_EN defined).
module multiplier
    import riscv_defs::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    multiplier_if.slave  bus
);
    mul_op_e     op;
    logic        capture;
    logic [32:0] a, b;
    logic [65:0] p;
    logic        unused_p_top;
    always_comb begin
        op      = decode_op(bus.is_mul_i, bus.is_mulh_i, bus.is_mulhsu_i);
        capture = bus.valid_i & (bus.is_mul_i | bus.is_mulh_i | bus.is_mulhsu_i | bus.is_mulhu_i);
        a       = {((op == OP_MULH) || (op == OP_MULHSU)) & bus.op1_i[XLEN-1], bus.op1_i};
        b       = {(op == OP_MULH) & bus.op2_i[XLEN-1], bus.op2_i};
    end
    mul_core u_core (
        .a (a),
        .b (b),
        .p (p)
    );
    assign unused_p_top = ^p[65:64];
`ifdef MULTIPLIER_PIPE2_EN
    logic [63:0] p_q;
    mul_op_e     op_q;
    logic        v_q;
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            v_q           <= 1'b0;
            bus.valid_o   <= 1'b0;
            bus.product_o <= '0;
        end else begin
            v_q         <= capture;
            bus.valid_o <= v_q;
            if (capture) begin
                p_q  <= p[63:0];
                op_q <= op;
            end
            if (v_q)
                bus.product_o <= (op_q == OP_MUL) ? p_q[31:0] : p_q[63:32];
        end
    end
`else
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            bus.valid_o   <= 1'b0;
            bus.product_o <= '0;
        end else begin
            bus.valid_o <= capture;
            if (capture)
                bus.product_o <= (op == OP_MUL) ? p[31:0] : p[63:32];
        end
    end
`endif
endmodule

// File: tb/tb_multiplier.sv
// tb_multiplier: table-driven vectors with an in-order expected-result queue for multiplier.
module tb_multiplier;
    import riscv_defs::*;
`ifdef MULTIPLIER_PIPE2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam logic [3:0] S_MUL = 4'b1000, S_MULH = 4'b0100, S_MULHSU = 4'b0010, S_MULHU = 4'b0001;
    localparam logic [31:0] F = 32'hFFFF_FFFF, M = 32'h8000_0000;

    typedef struct {
        logic        v;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;
    typedef struct {
        logic [31:0] exp;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    int total = 0, bad = 0, cyc = 0;
    bit chk_en = 1'b0;
    logic [31:0] last_prod = '0;
    exp_t q[$];
    vec_t tbl[14];

    always #5 clk = ~clk;

    multiplier_if bus ();
    multiplier dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
        logic [63:0] ea, eb, pr;
        ea = {{32{a[31] & ~s[3] & (s[2] | s[1])}}, a};
        eb = {{32{b[31] & ~s[3] & s[2]}}, b};
        pr = ea * eb;
        return s[3] ? pr[31:0] : pr[63:32];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] s, input logic [31:0] e);
        @(posedge clk);
        #1;
        rst_ni          = r;
        bus.valid_i     = v;
        bus.op1_i       = a;
        bus.op2_i       = b;
        bus.is_mul_i    = s[3];
        bus.is_mulh_i   = s[2];
        bus.is_mulhsu_i = s[1];
        bus.is_mulhu_i  = s[0];
        if (v && s != 4'b0)
            q.push_back('{e, cyc + LAT});
    endtask

    // Reset at an edge discards everything still in flight.
    always @(posedge clk) begin
        cyc++;
        if (!rst_ni) begin
            q.delete();
            last_prod = '0;
            chk_en = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (q.size() > 0 && q[0].due <= cyc) begin
                check("valid_o pulse", 32'(bus.valid_o), 32'd1);
                check("product_o result", bus.product_o, q[0].exp);
                last_prod = q[0].exp;
                void'(q.pop_front());
            end else begin
                check("valid_o idle", 32'(bus.valid_o), 32'd0);
                check("product_o hold", bus.product_o, last_prod);
            end
        end
    end

    initial begin
        bus.valid_i     = 1'b1;
        bus.op1_i       = 32'd2;
        bus.op2_i       = 32'd8;
        bus.is_mul_i    = 1'b1;
        bus.is_mulh_i   = 1'b0;
        bus.is_mulhsu_i = 1'b0;
        bus.is_mulhu_i  = 1'b0;
        tbl = '{
            '{1'b1, 32'd2, 32'd8, S_MUL,    32'h0000_0010},
            '{1'b1, F, F, S_MUL,    32'h0000_0001},
            '{1'b1, F, F, S_MULH,   32'h0000_0000},
            '{1'b1, F, F, S_MULHSU, 32'hFFFF_FFFF},
            '{1'b1, F, F, S_MULHU,  32'hFFFF_FFFE},
            '{1'b1, M, M, S_MULH,   32'h4000_0000},
            '{1'b1, M, M, S_MULHU,  32'h4000_0000},
            '{1'b1, M, M, S_MULHSU, 32'hC000_0000},
            '{1'b1, 32'h1234_5678, 32'h9ABC_DEF0, S_MUL, 32'h242D_2080},
            '{1'b0, F, F, S_MUL,    32'h0},
            '{1'b1, F, F, 4'b0000,  32'h0},
            '{1'b1, F, F, S_MUL | S_MULHU, 32'h0000_0001},
            '{1'b1, M, F, S_MULH | S_MULHSU | S_MULHU, 32'h0000_0000},
            '{1'b1, F, M, S_MULHSU | S_MULHU, 32'hFFFF_FFFF}
        };
        drive(1'b0, 1'b1, 32'd2, 32'd8, S_MUL, 32'h10);
        drive(1'b0, 1'b1, 32'd2, 32'd8, S_MUL, 32'h10);
        for (int i = 0; i < 14; i++)
            drive(1'b1, tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].sel, tbl[i].exp);
        for (int i = 0; i < 10; i++) begin
            logic [31:0] ra, rb;
            logic [3:0]  rs;
            ra = $urandom;
            rb = $urandom;
            rs = 4'b0001 << $urandom_range(0, 3);
            drive(1'b1, 1'b1, ra, rb, rs, ref_mul(ra, rb, rs));
        end
        drive(1'b1, 1'b0, F, F, S_MUL, 32'h0);
        drive(1'b1, 1'b1, F, F, S_MULHU, 32'hFFFF_FFFE);
        drive(1'b0, 1'b0, F, F, S_MUL, 32'h0);
        drive(1'b1, 1'b0, F, F, S_MUL, 32'h0);
        drive(1'b1, 1'b1, 32'd7, 32'd6, S_MUL, 32'd42);
        drive(1'b0, 1'b1, F, F, S_MUL, 32'h1);
        drive(1'b1, 1'b0, F, F, S_MUL, 32'h0);
        drive(1'b1, 1'b1, F, M, S_MULHU, 32'h7FFF_FFFF);
        drive(1'b0, 1'b1, F, F, S_MULH, 32'h0);
        repeat (LAT + 3) drive(1'b1, 1'b0, 32'h0, 32'h0, 4'b0000, 32'h0);
        check("queue drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
